// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
    localparam int unsigned PS2_FRAME_LEN  = 11;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser, saturating glitch filter and falling-edge strobe for one PS/2 line.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic fall_o
);

    localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic            meta_q, sync_q;
    logic            filt_q, filt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

    // The filtered level flips only after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(FILTER_LEN - 1)) begin
            filt_d = sync_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign fall_o = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix tracking.
// Optional held-key output enabled by defining PS2_KEY_HOLD_EN.
module ps2_scancode_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err
`ifdef PS2_KEY_HOLD_EN
    ,
    output logic [7:0] held_code
`endif
);

    localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    ps2_state_e      state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [7:0]      scancode_q, scancode_d;
    logic            code_valid_q, code_valid_d;
    logic            is_break_q, is_break_d;
    logic            is_ext_q, is_ext_d;
    logic            frame_err_q, frame_err_d;
    logic            ext_pend_q, ext_pend_d;
    logic            brk_pend_q, brk_pend_d;
    logic            data_meta_q, data_sync_q;
    logic            sample;
    logic            frame_ok;
`ifdef PS2_KEY_HOLD_EN
    logic [7:0]      held_q, held_d;
`endif

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .reset  (reset),
        .raw_i  (ps2_clk),
        .fall_o (sample)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    assign frame_ok = data_sync_q & (^{shift_q, parity_q});

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        tmo_d        = '0;
        scancode_d   = scancode_q;
        is_break_d   = is_break_q;
        is_ext_d     = is_ext_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
`ifdef PS2_KEY_HOLD_EN
        held_d       = held_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (sample && !data_sync_q) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (sample) begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
            end
            StParity: begin
                if (sample) begin
                    parity_d = data_sync_q;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (sample) begin
                    state_d = StIdle;
                    if (!frame_ok) begin
                        frame_err_d = 1'b1;
                        ext_pend_d  = 1'b0;
                        brk_pend_d  = 1'b0;
                    end else if (shift_q == PS2_PREFIX_EXT) begin
                        ext_pend_d = 1'b1;
                    end else if (shift_q == PS2_PREFIX_BRK) begin
                        brk_pend_d = 1'b1;
                    end else begin
                        scancode_d   = shift_q;
                        is_break_d   = brk_pend_q;
                        is_ext_d     = ext_pend_q;
                        code_valid_d = 1'b1;
                        ext_pend_d   = 1'b0;
                        brk_pend_d   = 1'b0;
`ifdef PS2_KEY_HOLD_EN
                        if (!brk_pend_q) begin
                            held_d = shift_q;
                        end else if (shift_q == held_q) begin
                            held_d = 8'h00;
                        end
`endif
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Mid-frame watchdog; a sample in the same cycle takes priority.
        if (state_q != StIdle && !sample) begin
            if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                frame_err_d = 1'b1;
                ext_pend_d  = 1'b0;
                brk_pend_d  = 1'b0;
                state_d     = StIdle;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tmo_q        <= '0;
            scancode_q   <= 8'h00;
            code_valid_q <= 1'b0;
            is_break_q   <= 1'b0;
            is_ext_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
`ifdef PS2_KEY_HOLD_EN
            held_q       <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            tmo_q        <= tmo_d;
            scancode_q   <= scancode_d;
            code_valid_q <= code_valid_d;
            is_break_q   <= is_break_d;
            is_ext_q     <= is_ext_d;
            frame_err_q  <= frame_err_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
`ifdef PS2_KEY_HOLD_EN
            held_q       <= held_d;
`endif
        end
    end

    assign scancode    = scancode_q;
    assign code_valid  = code_valid_q;
    assign is_break    = is_break_q;
    assign is_extended = is_ext_q;
    assign frame_err   = frame_err_q;
`ifdef PS2_KEY_HOLD_EN
    assign held_code   = held_q;
`endif

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver with a queue-based event model.
module tb_ps2_scancode_receiver;

    localparam int unsigned FILT = 8;
    localparam int unsigned TMO  = 2000;
    localparam int          HALF = 100;
    localparam int          GAP  = 400;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scancode;
    logic       code_valid;
    logic       is_break;
    logic       is_extended;
    logic       frame_err;
`ifdef PS2_KEY_HOLD_EN
    logic [7:0] held_code;
`endif

    ps2_scancode_receiver #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scancode    (scancode),
        .code_valid  (code_valid),
        .is_break    (is_break),
        .is_extended (is_extended),
        .frame_err   (frame_err)
`ifdef PS2_KEY_HOLD_EN
        ,
        .held_code   (held_code)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    int unsigned stop_fall_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int n_valid = 0;
    int n_err_seen = 0;

    // Model state: expected strobes in order, outstanding errors, pending prefixes.
    logic [7:0] q_code[$];
    bit         q_brk[$];
    bit         q_ext[$];
    int         exp_err = 0;
    bit         m_ext = 1'b0;
    bit         m_brk = 1'b0;
    logic [7:0] m_sc = 8'h00;
    logic [7:0] m_held = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_frame(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            q_code.push_back(b);
            q_brk.push_back(m_brk);
            q_ext.push_back(m_ext);
            m_sc = b;
            if (!m_brk) m_held = b;
            else if (b == m_held) m_held = 8'h00;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_reset();
        q_code.delete();
        q_brk.delete();
        q_ext.delete();
        exp_err = 0;
        m_ext   = 1'b0;
        m_brk   = 1'b0;
        m_sc    = 8'h00;
        m_held  = 8'h00;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic put_bit(input logic b, input bit is_stop);
        ps2_data = b;
        wait_cyc(HALF / 2);
        if (is_stop) stop_fall_cyc = cyc;
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par);
        logic p;
        p = (~^b) ^ flip_par;
        put_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) put_bit(b[i], 1'b0);
        put_bit(p, 1'b0);
        model_frame(b, !flip_par);
        put_bit(1'b1, 1'b1);
        ps2_data = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic send_partial(input logic [7:0] b);
        put_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) put_bit(b[i], 1'b0);
    endtask

    task automatic settle(input string name);
        chk({name, "_events_drained"}, q_code.size(), 0);
        chk({name, "_errors_drained"}, exp_err, 0);
        chk({name, "_scancode"}, int'(scancode), int'(m_sc));
`ifdef PS2_KEY_HOLD_EN
        chk({name, "_held_code"}, int'(held_code), int'(m_held));
`endif
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (code_valid) begin
                n_valid++;
                chk("code_valid_expected", int'(q_code.size() > 0), 1);
                if (q_code.size() > 0) begin
                    chk("strobe_scancode", int'(scancode), int'(q_code[0]));
                    chk("strobe_is_break", int'(is_break), int'(q_brk[0]));
                    chk("strobe_is_extended", int'(is_extended), int'(q_ext[0]));
                    chk("strobe_latency", int'((cyc - stop_fall_cyc) inside {[8:12]}), 1);
                    void'(q_code.pop_front());
                    void'(q_brk.pop_front());
                    void'(q_ext.pop_front());
                end
            end
            if (frame_err) begin
                n_err_seen++;
                chk("frame_err_expected", int'(exp_err > 0), 1);
                if (exp_err > 0) exp_err--;
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(3);
        chk("reset_scancode", int'(scancode), 8'h00);
        chk("reset_code_valid", int'(code_valid), 0);
        chk("reset_frame_err", int'(frame_err), 0);
        reset = 1'b0;
        wait_cyc(GAP);

        // Plain make code.
        send_frame(8'h16, 1'b0);
        settle("make_16");
        chk("make_16_lit_sc", int'(scancode), 8'h16);
        chk("make_16_lit_brk", int'(is_break), 0);
        chk("make_16_lit_ext", int'(is_extended), 0);

        // Make then break of 1E.
        send_frame(8'h1E, 1'b0);
        settle("make_1e");
`ifdef PS2_KEY_HOLD_EN
        chk("make_1e_lit_held", int'(held_code), 8'h1E);
`endif
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1E, 1'b0);
        settle("break_1e");
        chk("break_1e_lit_brk", int'(is_break), 1);
`ifdef PS2_KEY_HOLD_EN
        chk("break_1e_lit_held", int'(held_code), 8'h00);
`endif

        // Extended break.
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        settle("ext_break_75");
        chk("ext_break_lit_sc", int'(scancode), 8'h75);
        chk("ext_break_lit_brk", int'(is_break), 1);
        chk("ext_break_lit_ext", int'(is_extended), 1);

        // Parity error keeps scancode, next good frame decodes.
        send_frame(8'h26, 1'b1);
        settle("parity_err");
        chk("parity_err_lit_sc", int'(scancode), 8'h75);
        send_frame(8'h25, 1'b0);
        settle("after_parity");
        chk("after_parity_lit_ext", int'(is_extended), 0);

        // Timeout after start plus four data bits.
        send_partial(8'h3D);
        ps2_data = 1'b1;
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        wait_cyc(int'(TMO) + 500);
        settle("timeout");
        send_frame(8'h3D, 1'b0);
        settle("after_timeout");

        // Reset mid-frame.
        send_partial(8'h55);
        reset = 1'b1;
        #1;
        model_reset();
        chk("midreset_scancode", int'(scancode), 8'h00);
        chk("midreset_code_valid", int'(code_valid), 0);
        chk("midreset_is_break", int'(is_break), 0);
        chk("midreset_is_extended", int'(is_extended), 0);
`ifdef PS2_KEY_HOLD_EN
        chk("midreset_held", int'(held_code), 8'h00);
`endif
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(GAP);
        send_frame(8'h3E, 1'b0);
        settle("after_reset");

        // Short low glitch on ps2_clk with data low must not start a frame.
        ps2_data = 1'b0;
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(20);
        ps2_data = 1'b1;
        wait_cyc(GAP);
        send_frame(8'h16, 1'b0);
        settle("after_glitch");

        chk("total_code_valid", n_valid, 8);
        chk("total_frame_err", n_err_seen, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
